siren_pattern_ctrl: RTL and testbench

- Sequencer that drives the red/blue siren lamps from a selectable flash pattern.
- Sits between the mode/enable control inputs and the lamp outputs, and owns all the timing.
- One prescaler produces a tick. A state machine steps through the active pattern on ticks.
- Mode changes restart the pattern cleanly, with no partial phases.

---
 rtl/siren_pattern_ctrl.sv | 161 ++++++++++++++++
 tb/tb_siren_pattern_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/siren_pattern_ctrl.sv
// Siren lamp sequencer: a prescaler tick drives an FSM through the selected
// red/blue flash pattern; mode reloads and en drops restart the pattern from its start.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | not running (en=0 or mode OFF), lamps dark
// ALT_RED    | ALTERNATE, red phase of FLASH_TICKS ticks
// ALT_BLUE   | ALTERNATE, blue phase of FLASH_TICKS ticks
// BST_RED    | BURST, BURST_LEN on/off pairs on red (sub_q=0 is the on tick)
// BST_BLUE   | BURST, BURST_LEN on/off pairs on blue
// STEADY     | both lamps on, prescaler held
module siren_pattern_ctrl #(
  parameter int         TICK_DIV    = 50,
  parameter int         FLASH_TICKS = 4,
  parameter int         BURST_LEN   = 3,
  parameter logic [1:0] RESET_MODE  = 2'd1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       mode_load,
  output logic       red_out,
  output logic       blue_out,
  output logic       active,
  output logic [1:0] mode_cur
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] PHASE_MAX = FW'(FLASH_TICKS - 1);
  localparam logic [BW-1:0] FLASH_MAX = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, ALT_RED, ALT_BLUE, BST_RED, BST_BLUE, STEADY
  } state_t;

  state_t          state_q, state_d, start_state;
  logic [PW-1:0]   presc_q, presc_d;
  logic [FW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   flash_q, flash_d;
  logic            sub_q, sub_d;
  logic            reload_q;
  logic            running, tick;
  logic            red_d, blue_d;

  assign running = en && (mode_cur != 2'd0);
  assign tick    = (state_q inside {ALT_RED, ALT_BLUE, BST_RED, BST_BLUE}) &&
                   (presc_q == PRESC_MAX);

  always_comb begin
    start_state = IDLE;
    case (mode_cur)
      2'd1:    start_state = ALT_RED;
      2'd2:    start_state = BST_RED;
      2'd3:    start_state = STEADY;
      default: start_state = IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    phase_d = phase_q;
    flash_d = flash_q;
    sub_d   = sub_q;
    if (!running) begin
      state_d = IDLE;
      phase_d = '0;
      flash_d = '0;
      sub_d   = 1'b0;
    end else if (reload_q || state_q == IDLE) begin
      // a reload takes effect one edge after mode_cur changes, always from a clean start
      state_d = start_state;
      phase_d = '0;
      flash_d = '0;
      sub_d   = 1'b0;
    end else begin
      case (state_q)
        ALT_RED, ALT_BLUE: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (phase_q == PHASE_MAX) begin
              phase_d = '0;
              state_d = (state_q == ALT_RED) ? ALT_BLUE : ALT_RED;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        BST_RED, BST_BLUE: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            sub_d = ~sub_q;
            if (sub_q) begin
              if (flash_q == FLASH_MAX) begin
                flash_d = '0;
                state_d = (state_q == BST_RED) ? BST_BLUE : BST_RED;
              end else begin
                flash_d = flash_q + 1'b1;
              end
            end
          end
        end
        STEADY:  state_d = STEADY;
        default: state_d = IDLE;
      endcase
    end
  end

  // lamps follow the registered state one cycle later, but blank at once when running drops
  always_comb begin
    red_d  = 1'b0;
    blue_d = 1'b0;
    if (running) begin
      case (state_q)
        ALT_RED:  red_d  = 1'b1;
        ALT_BLUE: blue_d = 1'b1;
        BST_RED:  red_d  = ~sub_q;
        BST_BLUE: blue_d = ~sub_q;
        STEADY: begin
          red_d  = 1'b1;
          blue_d = 1'b1;
        end
        default: begin
          red_d  = 1'b0;
          blue_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      phase_q  <= '0;
      flash_q  <= '0;
      sub_q    <= 1'b0;
      reload_q <= 1'b0;
      mode_cur <= RESET_MODE;
      red_out  <= 1'b0;
      blue_out <= 1'b0;
      active   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      flash_q  <= flash_d;
      sub_q    <= sub_d;
      reload_q <= mode_load;
      if (mode_load) mode_cur <= mode;
      red_out  <= red_d;
      blue_out <= blue_d;
      active   <= running;
    end
  end

endmodule

// File: tb/tb_siren_pattern_ctrl.sv
// Directed bench for siren_pattern_ctrl with TICK_DIV=4, FLASH_TICKS=2, BURST_LEN=3:
// alternate phases of 8 cycles, burst flashes of 4 on / 4 off.
module tb_siren_pattern_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       mode_load;
  logic       red_out;
  logic       blue_out;
  logic       active;
  logic [1:0] mode_cur;

  int n_cmp = 0;
  int n_err = 0;

  siren_pattern_ctrl #(
    .TICK_DIV(4), .FLASH_TICKS(2), .BURST_LEN(3), .RESET_MODE(2'd1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .mode(mode), .mode_load(mode_load),
    .red_out(red_out), .blue_out(blue_out), .active(active), .mode_cur(mode_cur)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_lamps(input string tag, input logic er, input logic eb);
    check({tag, "_red"}, {1'b0, red_out}, {1'b0, er});
    check({tag, "_blue"}, {1'b0, blue_out}, {1'b0, eb});
    check({tag, "_excl"}, {1'b0, red_out & blue_out}, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; mode_load = 1'b0;
    repeat (3) step();
    check("rst_red", {1'b0, red_out}, 2'd0);
    check("rst_blue", {1'b0, blue_out}, 2'd0);
    check("rst_active", {1'b0, active}, 2'd0);
    check("rst_mode_cur", mode_cur, 2'd1);

    // release: IDLE exits on the first edge, red follows one cycle later
    rst_n = 1'b1;
    step();
    check("start_red", {1'b0, red_out}, 2'd0);
    check("start_active", {1'b0, active}, 2'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      check_lamps("alt", (i % 16) < 8, (i % 16) >= 8);
    end

    // mid-phase reload three cycles into ALT_BLUE
    step();
    check_lamps("blue_ph1", 1'b0, 1'b1);
    step();
    check_lamps("blue_ph2", 1'b0, 1'b1);
    mode = 2'd1; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    check("reload_mode_cur", mode_cur, 2'd1);
    check_lamps("reload_e0", 1'b0, 1'b1);
    step();
    check_lamps("reload_e1", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      check_lamps("reload_alt", i < 8, i >= 8);
    end

    // burst
    mode = 2'd2; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    check("burst_mode_cur", mode_cur, 2'd2);
    step();
    for (int i = 0; i < 56; i++) begin
      int j;
      j = i % 48;
      step();
      check_lamps("burst", (j < 24) && ((j % 8) < 4), (j >= 24) && (((j - 24) % 8) < 4));
    end

    // en gating during BST_RED, then a STEADY load while disabled
    en = 1'b0;
    step();
    check_lamps("en_drop", 1'b0, 1'b0);
    check("en_drop_active", {1'b0, active}, 2'd0);
    mode = 2'd3; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    check("dis_load_mode_cur", mode_cur, 2'd3);
    check_lamps("dis_load", 1'b0, 1'b0);
    repeat (3) step();
    check_lamps("dis_hold", 1'b0, 1'b0);
    check("dis_hold_active", {1'b0, active}, 2'd0);
    en = 1'b1;
    step();
    check("en_rise_active", {1'b0, active}, 2'd1);
    check("en_rise_red", {1'b0, red_out}, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("steady_both", {red_out, blue_out}, 2'b11);
    end

    // OFF mode with en=1
    mode = 2'd0; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    check("off_mode_cur", mode_cur, 2'd0);
    check("off_e0", {red_out, blue_out}, 2'b11);
    for (int i = 0; i < 20; i++) begin
      step();
      check_lamps("off", 1'b0, 1'b0);
      check("off_active", {1'b0, active}, 2'd0);
    end

    // async reset in the middle of a burst flash
    mode = 2'd2; mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    step();
    check_lamps("pre_arst_idle", 1'b0, 1'b0);
    step();
    check_lamps("pre_arst", 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_lamps("arst", 1'b0, 1'b0);
    check("arst_active", {1'b0, active}, 2'd0);
    check("arst_mode_cur", mode_cur, 2'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rerun_red", {1'b0, red_out}, 2'd0);
    check("rerun_active", {1'b0, active}, 2'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      check_lamps("rerun_alt", i < 8, i >= 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
